alu: RTL and testbench
======================

Name: alu

Overview:
Single-cycle-issue integer ALU for the execute stage of the superscalar core. It takes a 12-bit one-hot operation vector from decode, two 16-bit register operands and a 5-bit immediate. It produces a registered 16-bit result one clock after the inputs are presented. Load and store use the adder to form effective addresses.

Parameters:
- WIDTH, 16, datapath width of op1, op2 and aluresult.
- IMM_WIDTH, 5, width of the immediate field immx.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- alusignals  input  12  one-hot operation select; bit map is given in Behaviour.
- op1  input  WIDTH  operand A (rs1).
- op2  input  WIDTH  register operand B (rs2).
- immx  input  IMM_WIDTH  immediate operand.
- isimmediate  input  1  1 = operand B comes from immx; 0 = operand B is op2.
- aluresult  output  WIDTH  registered result.

Behaviour:
- Bit map of alusignals:
  - [0] add, [1] ld, [2] st, [3] sub
  - [4] mul, [5] cmp, [6] mov, [7] or
  - [8] and, [9] not, [10] lsl, [11] lsr
- Operand B: B = isimmediate ? sign_extend(immx) to WIDTH : op2. Operand A is always op1.
- Operations (all modulo 2^WIDTH, unsigned wrap, no overflow flag):
  - add, ld, st: A+B.
  - sub: A-B.
  - mul: low WIDTH bits of A*B.
  - cmp: {zeros, gt, eq}. eq = (A==B); gt = signed(A) > signed(B). Bit1 = gt, bit0 = eq, upper bits 0.
  - mov: B.
  - or: A|B.
  - and: A&B.
  - not: ~B.
  - lsl: A << B, logical; zero fill.
  - lsr: A >> B, logical; zero fill.
  - Shift amount is the unsigned value of B. If B >= WIDTH, the result is 0.
- Latency: the result is computed combinationally from the current inputs and captured into aluresult on the next rising edge. aluresult is stable for the whole following cycle.
- Select conflicts:
  - If alusignals is all zero, aluresult loads 0 on the next edge.
  - If more than one bit is set, the lowest-numbered set bit wins (fixed priority 0 to 11).
- Reset:
  - When rst=1 at a rising edge, aluresult becomes 0, regardless of alusignals.
  - Reset dominates any operation presented in the same cycle.
  - The first edge with rst=0 captures the then-current operation normally.
- No internal state other than the aluresult register. No handshake; a new operation is accepted every cycle.

Decomposition:
- Package alu_pkg holds:
  - localparam bit indices ALU_ADD=0 … ALU_LSR=11 and ALU_NUM_OPS=12.
  - WIDTH/IMM_WIDTH defaults.
  - The cmp result bit positions (CMP_EQ=0, CMP_GT=1).
- Decode, execute and the bench import it.
- One natural sub-module, alu_shifter: combinational lsl/lsr with saturation to 0 for shift amounts >= WIDTH.
- The adder/subtractor, multiplier, logic, cmp and result mux stay in alu.

Test Plan:
- Reset: drive rst=1 for 2 edges with alusignals=12'h001, op1=5, op2=3 → aluresult=0000. Release rst → next edge gives 0008.
- Register ops with op1=16'h0005, op2=16'h0003, isimmediate=0, one op per cycle, checked one edge later:
  - add/ld/st → 0008
  - sub → 0002
  - mul → 000F
  - cmp → 0002
  - mov → 0003
  - or → 0007
  - and → 0001
  - not → FFFC
  - lsl → 0028
  - lsr → 0000
- Immediate path: isimmediate=1, immx=5'b11111 (-1), op1=5:
  - add → 0004
  - mov → FFFF
  - cmp → 0002 (5 > -1)
  - lsr → 0000 (shift >= 16)
- Wrap and equality:
  - op1=FFFF, op2=0001: add → 0000; sub with op1=0, op2=1 → FFFF.
  - op1=op2=1234: cmp → 0001.
  - op1=0100, op2=0100: mul → 0000 (low bits).
- Select corner cases:
  - alusignals=0 → 0000.
  - alusignals=12'h009 (add+sub), op1=5, op2=3 → 0008 (add wins).
  - Back-to-back op changes every cycle → each result appears exactly one edge after its inputs.
- Shift boundaries with op1=8001:
  - lsl by 1 → 0002
  - lsr by 15 → 0001
  - lsl by 16 → 0000

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the execute-stage integer ALU.
//   - Bit positions of each operation inside the one-hot alusignals vector.
//   - Default datapath and immediate widths.
//   - Bit positions of the eq/gt flags inside a cmp result.
package alu_pkg;

    localparam int ALU_DEFAULT_WIDTH     = 16;
    localparam int ALU_DEFAULT_IMM_WIDTH = 5;

    localparam int ALU_ADD     = 0;
    localparam int ALU_LD      = 1;
    localparam int ALU_ST      = 2;
    localparam int ALU_SUB     = 3;
    localparam int ALU_MUL     = 4;
    localparam int ALU_CMP     = 5;
    localparam int ALU_MOV     = 6;
    localparam int ALU_OR      = 7;
    localparam int ALU_AND     = 8;
    localparam int ALU_NOT     = 9;
    localparam int ALU_LSL     = 10;
    localparam int ALU_LSR     = 11;
    localparam int ALU_NUM_OPS = 12;

    localparam int CMP_EQ = 0;
    localparam int CMP_GT = 1;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational logical shifter for lsl/lsr.
// Ports:
//   value    - operand to shift (operand A)
//   amount   - unsigned shift distance (operand B)
//   shiftleft- 1 = shift left, 0 = shift right; both zero fill
//   shifted  - shift result, forced to 0 when amount >= WIDTH
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] amount,
    input  logic             shiftleft,
    output logic [WIDTH-1:0] shifted
);

    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH[WIDTH-1:0];

    // Any distance at or beyond the datapath width moves every bit out,
    // so the result saturates to zero instead of relying on operator
    // semantics for oversized shift counts.
    always_comb begin
        shifted = '0;
        if (amount < SHIFT_LIMIT) begin
            if (shiftleft) begin
                shifted = value << amount;
            end else begin
                shifted = value >> amount;
            end
        end
    end

endmodule

// File: rtl/alu.sv
// alu: single-cycle-issue integer ALU for the execute stage.
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset, clears aluresult
//   alusignals  - one-hot operation select (lowest set bit wins)
//   op1         - operand A
//   op2         - register operand B
//   immx        - immediate, sign-extended when used as operand B
//   isimmediate - 1 selects immx as operand B, 0 selects op2
//   aluresult   - result registered one edge after the inputs
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH     = ALU_DEFAULT_WIDTH,
    parameter int IMM_WIDTH = ALU_DEFAULT_IMM_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ALU_NUM_OPS-1:0] alusignals,
    input  logic [WIDTH-1:0]       op1,
    input  logic [WIDTH-1:0]       op2,
    input  logic [IMM_WIDTH-1:0]   immx,
    input  logic                   isimmediate,
    output logic [WIDTH-1:0]       aluresult
);

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sumresult;
    logic [WIDTH-1:0] diffresult;
    logic [WIDTH-1:0] mulresult;
    logic [WIDTH-1:0] cmpresult;
    logic [WIDTH-1:0] shiftresult;
    logic [WIDTH-1:0] nextresult;

    assign opa = op1;
    assign opb = isimmediate ? {{(WIDTH-IMM_WIDTH){immx[IMM_WIDTH-1]}}, immx} : op2;

    // Arithmetic in the operand width gives the modulo-2^WIDTH wrap directly;
    // the multiply keeps only the low half of the product.
    assign sumresult  = opa + opb;
    assign diffresult = opa - opb;
    assign mulresult  = opa * opb;

    // Compare packs equality and signed greater-than into the low bits.
    always_comb begin
        cmpresult         = '0;
        cmpresult[CMP_EQ] = (opa == opb);
        cmpresult[CMP_GT] = ($signed(opa) > $signed(opb));
    end

    // Only lsr needs a right shift; every other case the mux ignores this.
    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .value     (opa),
        .amount    (opb),
        .shiftleft (~alusignals[ALU_LSR] | alusignals[ALU_LSL]),
        .shifted   (shiftresult)
    );

    // Fixed-priority result select: the lowest-numbered set bit decides,
    // and an empty select produces zero.
    always_comb begin
        nextresult = '0;
        if (alusignals[ALU_ADD] || alusignals[ALU_LD] || alusignals[ALU_ST]) begin
            nextresult = sumresult;
        end else if (alusignals[ALU_SUB]) begin
            nextresult = diffresult;
        end else if (alusignals[ALU_MUL]) begin
            nextresult = mulresult;
        end else if (alusignals[ALU_CMP]) begin
            nextresult = cmpresult;
        end else if (alusignals[ALU_MOV]) begin
            nextresult = opb;
        end else if (alusignals[ALU_OR]) begin
            nextresult = opa | opb;
        end else if (alusignals[ALU_AND]) begin
            nextresult = opa & opb;
        end else if (alusignals[ALU_NOT]) begin
            nextresult = ~opb;
        end else if (alusignals[ALU_LSL] || alusignals[ALU_LSR]) begin
            nextresult = shiftresult;
        end
    end

    // The only state in the block: reset wins over any operation presented
    // in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            aluresult <= '0;
        end else begin
            aluresult <= nextresult;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. Directed vectors with literal
// expectations, then randomized traffic checked every cycle against an
// integer-arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [11:0] alusignals;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [4:0]  immx;
    logic        isimmediate;
    logic [15:0] aluresult;

    int vectors    = 0;
    int miscompares = 0;
    bit running    = 1'b1;

    alu #(.WIDTH(16), .IMM_WIDTH(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .alusignals  (alusignals),
        .op1         (op1),
        .op2         (op2),
        .immx        (immx),
        .isimmediate (isimmediate),
        .aluresult   (aluresult)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: evaluates the operation from the rules with plain
    // integer arithmetic, masking to 16 bits at the end.
    function automatic logic [15:0] model(input logic rstv, input logic [11:0] sig,
                                          input logic [15:0] a, input logic [15:0] b2,
                                          input logic [4:0] imm, input logic isimm);
        int sel;
        int ua;
        int ub;
        int iv;
        int sa;
        int sb;
        int res;
        longint prod;
        logic [31:0] resbits;
        sel = -1;
        for (int i = 0; i < 12; i++) begin
            if (sig[i] && sel < 0) sel = i;
        end
        ua = int'(a);
        iv = int'(imm);
        if (isimm) ub = ((iv < 16) ? iv : iv - 32) & 'hFFFF;
        else       ub = int'(b2);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        res = 0;
        case (sel)
            0, 1, 2: res = ua + ub;
            3:       res = ua - ub;
            4: begin
                prod = longint'(ua) * longint'(ub);
                res  = int'(prod & 64'hFFFF);
            end
            5:  res = ((sa > sb) ? 2 : 0) + ((ua == ub) ? 1 : 0);
            6:  res = ub;
            7:  res = ua | ub;
            8:  res = ua & ub;
            9:  res = ~ub;
            10: res = (ub >= 16) ? 0 : (ua << ub);
            11: res = (ub >= 16) ? 0 : (ua >> ub);
            default: res = 0;
        endcase
        if (rstv) res = 0;
        resbits = res & 'hFFFF;
        return resbits[15:0];
    endfunction

    // Every cycle: predict what the DUT captures at this edge from the
    // inputs that were stable across it, then compare just after the edge.
    initial begin
        logic [15:0] expected;
        while (running) begin
            @(posedge clk);
            expected = model(rst, alusignals, op1, op2, immx, isimmediate);
            #1;
            vectors++;
            if (aluresult !== expected) begin
                miscompares++;
                $display("[TB] FAIL model t=%0t aluresult=%h expected=%h", $time, aluresult, expected);
            end
        end
    end

    // Drive one set of inputs and let exactly one rising edge capture them.
    task automatic applyStimulus(input logic r, input logic [11:0] sig,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [4:0] imm, input logic isimm);
        rst         = r;
        alusignals  = sig;
        op1         = a;
        op2         = b;
        immx        = imm;
        isimmediate = isimm;
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] required);
        vectors++;
        if (aluresult !== required) begin
            miscompares++;
            $display("[TB] FAIL %s aluresult=%h required=%h", name, aluresult, required);
        end
    endtask

    task automatic checkModel(input string name, input logic [15:0] got, input logic [15:0] required);
        vectors++;
        if (got !== required) begin
            miscompares++;
            $display("[TB] FAIL model-pin %s model=%h required=%h", name, got, required);
        end
    endtask

    initial begin
        logic [11:0] sig;
        logic [15:0] a;
        logic [15:0] b;
        rst = 1'b1; alusignals = 12'h001; op1 = 16'd5; op2 = 16'd3; immx = '0; isimmediate = 1'b0;

        // Pin the model itself with hand-computed values.
        checkModel("add", model(1'b0, 12'h001, 16'h0005, 16'h0003, 5'd0, 1'b0), 16'h0008);
        checkModel("cmp-imm", model(1'b0, 12'h020, 16'h0005, 16'h0000, 5'h1F, 1'b1), 16'h0002);
        checkModel("lsr-sat", model(1'b0, 12'h800, 16'h8001, 16'd16, 5'd0, 1'b0), 16'h0000);
        checkModel("mul-wrap", model(1'b0, 12'h010, 16'h0100, 16'h0100, 5'd0, 1'b0), 16'h0000);

        // Reset holds zero for two edges, release captures the add.
        applyStimulus(1'b1, 12'h001, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("reset1", 16'h0000);
        applyStimulus(1'b1, 12'h001, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("reset2", 16'h0000);
        applyStimulus(1'b0, 12'h001, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("release", 16'h0008);

        // Register operands 5 and 3, one op per cycle.
        applyStimulus(1'b0, 12'h002, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("ld",  16'h0008);
        applyStimulus(1'b0, 12'h004, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("st",  16'h0008);
        applyStimulus(1'b0, 12'h008, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("sub", 16'h0002);
        applyStimulus(1'b0, 12'h010, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("mul", 16'h000F);
        applyStimulus(1'b0, 12'h020, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("cmp", 16'h0002);
        applyStimulus(1'b0, 12'h040, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("mov", 16'h0003);
        applyStimulus(1'b0, 12'h080, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("or",  16'h0007);
        applyStimulus(1'b0, 12'h100, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("and", 16'h0001);
        applyStimulus(1'b0, 12'h200, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("not", 16'hFFFC);
        applyStimulus(1'b0, 12'h400, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("lsl", 16'h0028);
        applyStimulus(1'b0, 12'h800, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("lsr", 16'h0000);

        // Immediate -1 as operand B.
        applyStimulus(1'b0, 12'h001, 16'd5, 16'd3, 5'h1F, 1'b1); checkOutput("imm-add", 16'h0004);
        applyStimulus(1'b0, 12'h040, 16'd5, 16'd3, 5'h1F, 1'b1); checkOutput("imm-mov", 16'hFFFF);
        applyStimulus(1'b0, 12'h020, 16'd5, 16'd3, 5'h1F, 1'b1); checkOutput("imm-cmp", 16'h0002);
        applyStimulus(1'b0, 12'h800, 16'd5, 16'd3, 5'h1F, 1'b1); checkOutput("imm-lsr", 16'h0000);
        applyStimulus(1'b0, 12'h400, 16'd5, 16'd3, 5'h02, 1'b1); checkOutput("imm-lsl", 16'h0014);

        // Wrap-around and equality.
        applyStimulus(1'b0, 12'h001, 16'hFFFF, 16'h0001, 5'd0, 1'b0); checkOutput("add-wrap", 16'h0000);
        applyStimulus(1'b0, 12'h008, 16'h0000, 16'h0001, 5'd0, 1'b0); checkOutput("sub-wrap", 16'hFFFF);
        applyStimulus(1'b0, 12'h020, 16'h1234, 16'h1234, 5'd0, 1'b0); checkOutput("cmp-eq",  16'h0001);
        applyStimulus(1'b0, 12'h020, 16'h8000, 16'h0001, 5'd0, 1'b0); checkOutput("cmp-neg", 16'h0000);
        applyStimulus(1'b0, 12'h010, 16'h0100, 16'h0100, 5'd0, 1'b0); checkOutput("mul-low", 16'h0000);

        // Select corner cases.
        applyStimulus(1'b0, 12'h000, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("no-op",    16'h0000);
        applyStimulus(1'b0, 12'h009, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("add+sub",  16'h0008);
        applyStimulus(1'b0, 12'hC00, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("lsl+lsr",  16'h0028);
        applyStimulus(1'b0, 12'h280, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("or+not",   16'h0007);

        // Shift boundaries.
        applyStimulus(1'b0, 12'h400, 16'h8001, 16'd1,  5'd0, 1'b0); checkOutput("lsl1",  16'h0002);
        applyStimulus(1'b0, 12'h800, 16'h8001, 16'd15, 5'd0, 1'b0); checkOutput("lsr15", 16'h0001);
        applyStimulus(1'b0, 12'h400, 16'h8001, 16'd16, 5'd0, 1'b0); checkOutput("lsl16", 16'h0000);

        // Reset dominating an op mid-stream, then normal capture resumes.
        applyStimulus(1'b1, 12'h200, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("reset-mid", 16'h0000);
        applyStimulus(1'b0, 12'h200, 16'd5, 16'd3, 5'd0, 1'b0); checkOutput("after-rst", 16'hFFFC);

        // Randomized back-to-back traffic; the per-cycle model check covers it.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       sig = 12'h000;
                1, 2:    sig = 12'($urandom);
                default: sig = 12'(1) << $urandom_range(0, 11);
            endcase
            a = 16'($urandom);
            b = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            applyStimulus(($urandom_range(0, 19) == 0), sig, a, b,
                          5'($urandom), 1'($urandom));
        end

        running = 1'b0;
        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
